// File: rtl/coin_acceptor.sv
// Coin acceptor: collects nickels/dimes/quarters toward an item cost and hands a payment record to the change box.
// Optional idle auto-cancel in COLLECT is compiled in with `define COIN_TIMEOUT_EN.
module coin_acceptor #(
   parameter int TIMEOUT_CYCLES = 200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] cost,
   input  logic       coin_valid,
   input  logic [1:0] coin_type,
   output logic       coin_ready,
   input  logic       cancel,
   output logic       coin_reject,
   output logic [3:0] paid,
   output logic       pay_valid,
   input  logic       pay_ready,
   output logic [3:0] pay_cost,
   output logic [3:0] pay_paid,
   output logic       pay_cancel
);

   typedef enum logic [1:0] {IDLE, COLLECT, HANDOFF} state_t;

   state_t     state_reg, state_next;
   logic [3:0] cost_reg, cost_next;
   logic [3:0] paid_reg, paid_next;
   logic       coin_reject_reg, coin_reject_next;
   logic       pay_cancel_reg, pay_cancel_next;

   logic       coin_taken;
   logic [2:0] coin_value;
   logic [4:0] coin_sum;
   logic       coin_bad;
   logic       timeout_hit;

   // Catch an out-of-range timeout at elaboration rather than silently truncating it.
   generate
      if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
         $error("coin_acceptor: TIMEOUT_CYCLES must be 1..255");
      end
   endgenerate

   assign coin_taken = coin_valid && (state_reg == COLLECT);

   always_comb begin
      coin_value = 3'd0;
      case (coin_type)
         2'b01:   coin_value = 3'd1;
         2'b10:   coin_value = 3'd2;
         2'b11:   coin_value = 3'd5;
         default: coin_value = 3'd0;
      endcase
   end

   // Five-bit sum so an overflowing coin is refused instead of wrapping the total.
   assign coin_sum = {1'b0, paid_reg} + {2'b00, coin_value};
   assign coin_bad = (coin_type == 2'b00) || (coin_sum > 5'd15);

`ifdef COIN_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   logic [7:0] timer_reg, timer_next;

   always_comb begin
      timer_next  = 8'd0;
      timeout_hit = 1'b0;
      if (state_reg == COLLECT && !coin_taken) begin
         timer_next  = timer_reg + 8'd1;
         timeout_hit = (timer_next == TIMEOUT_LIMIT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_reg <= 8'd0;
      end else begin
         timer_reg <= timer_next;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Datapath next values.
   always_comb begin
      cost_next        = cost_reg;
      paid_next        = paid_reg;
      coin_reject_next = 1'b0;
      pay_cancel_next  = pay_cancel_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               cost_next       = cost;
               paid_next       = 4'd0;
               pay_cancel_next = 1'b0;
            end
         end
         COLLECT: begin
            if (coin_taken) begin
               if (coin_bad) begin
                  coin_reject_next = 1'b1;
               end else begin
                  paid_next = coin_sum[3:0];
               end
            end
            if (cancel || timeout_hit) begin
               pay_cancel_next = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // State register and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         cost_reg        <= 4'd0;
         paid_reg        <= 4'd0;
         coin_reject_reg <= 1'b0;
         pay_cancel_reg  <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cost_reg        <= cost_next;
         paid_reg        <= paid_next;
         coin_reject_reg <= coin_reject_next;
         pay_cancel_reg  <= pay_cancel_next;
      end
   end

   // Next-state logic; a sale completes on the same edge that brings paid up to cost.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = (cost == 4'd0) ? HANDOFF : COLLECT;
            end
         end
         COLLECT: begin
            if (cancel || timeout_hit || (paid_next >= cost_reg)) begin
               state_next = HANDOFF;
            end
         end
         HANDOFF: begin
            if (pay_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs decoded from state and registers only.
   always_comb begin
      coin_ready  = (state_reg == COLLECT);
      pay_valid   = (state_reg == HANDOFF);
      pay_cost    = (state_reg == HANDOFF && !pay_cancel_reg) ? cost_reg : 4'd0;
      pay_paid    = (state_reg == HANDOFF) ? paid_reg : 4'd0;
      pay_cancel  = pay_cancel_reg;
      coin_reject = coin_reject_reg;
      paid        = paid_reg;
   end

endmodule
